// File: rtl/ksa.sv
// ksa - ARC4 key-scheduling stage.
//
// Permutes the 256-byte S memory in place with a 24-bit key, after init has
// loaded S[i]=i. Each of the 256 iterations does two reads and two writes
// over six cycles: read S[i], update j, read S[j], then write the swapped
// bytes back. The result is handed on to the PRGA stage.
//
// Ports:
//   clk     rising-edge system clock
//   rst     asynchronous active-high reset
//   en      start request, sampled only while rdy is high
//   rdy     high when idle and able to accept a request
//   key     ARC4 key, big-endian (key[0] is key[23:16])
//   addr    S memory address
//   rddata  S memory read data, valid one cycle after addr
//   wrdata  S memory write data
//   wren    S memory write enable
module ksa #(
   parameter int KEYLEN = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   output logic                  rdy,
   input  logic [8*KEYLEN-1:0]   key,
   output logic [7:0]            addr,
   input  logic [7:0]            rddata,
   output logic [7:0]            wrdata,
   output logic                  wren
);

   typedef enum logic [2:0] {
      IDLE,
      READ_I,
      LATCH_I,
      READ_J,
      LATCH_J,
      WRITE_I,
      WRITE_J
   } state_t;

   state_t                state;
   state_t                next_state;
   logic                  armed;
   logic                  start;
   logic [7:0]            i;
   logic [7:0]            j;
   logic [7:0]            si;
   logic [7:0]            sj;
   logic [8*KEYLEN-1:0]   key_reg;
   logic [1:0]            kidx;
   logic [7:0]            keybyte;

   // State register. Reset parks the machine in IDLE; rdy is held low there
   // until armed comes up on the first edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and output decode. Outputs depend only on registered state
   // (state, i, j, si, sj, armed), never on rddata in the same cycle.
   always_comb begin
      next_state = state;
      start      = 1'b0;
      rdy        = 1'b0;
      addr       = 8'd0;
      wrdata     = 8'd0;
      wren       = 1'b0;
      case (state)
         IDLE: begin
            rdy = armed;
            if (armed && en) begin
               start      = 1'b1;
               next_state = READ_I;
            end
         end
         READ_I: begin
            addr       = i;
            next_state = LATCH_I;
         end
         LATCH_I: begin
            addr       = i;
            next_state = READ_J;
         end
         READ_J: begin
            addr       = j;
            next_state = LATCH_J;
         end
         LATCH_J: begin
            addr       = j;
            next_state = WRITE_I;
         end
         WRITE_I: begin
            addr       = i;
            wrdata     = sj;
            wren       = 1'b1;
            next_state = WRITE_J;
         end
         WRITE_J: begin
            addr       = j;
            wrdata     = si;
            wren       = 1'b1;
            next_state = (i == 8'hFF) ? IDLE : READ_I;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Key byte for the current iteration, picked by the mod-3 counter so no
   // divider is needed.
   always_comb begin
      keybyte = 8'd0;
      case (kidx)
         2'd0:    keybyte = key_reg[23:16];
         2'd1:    keybyte = key_reg[15:8];
         default: keybyte = key_reg[7:0];
      endcase
   end

   // Datapath registers. The key is captured at the start edge so later key
   // changes are ignored. j is updated in LATCH_I so READ_J already sees the
   // new value. i stops at 255; the run ends on the i==255 test in WRITE_J.
   // When i==j both writes land on the same byte with the same value, which
   // is harmless, so no special case exists for it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed   <= 1'b0;
         i       <= 8'd0;
         j       <= 8'd0;
         si      <= 8'd0;
         sj      <= 8'd0;
         key_reg <= '0;
         kidx    <= 2'd0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  key_reg <= key;
                  i       <= 8'd0;
                  j       <= 8'd0;
                  kidx    <= 2'd0;
               end
            end
            LATCH_I: begin
               si <= rddata;
               j  <= j + rddata + keybyte;
            end
            LATCH_J: begin
               sj <= rddata;
            end
            WRITE_J: begin
               if (i != 8'hFF) begin
                  i    <= i + 8'd1;
                  kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ksa.sv
// tb_ksa - directed self-checking bench for ksa.
//
// Drives ksa against a synchronous 256-byte S memory model with one-cycle
// read latency and compares the final S contents with a software ARC4 KSA
// model. A monitor forked from the main sequence follows the six-cycle
// iteration pattern and checks wren, rdy, the i address sequence and the
// number of writes per run.
module tb_ksa;

   logic        clk;
   logic        rst;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  addr;
   logic [7:0]  rddata;
   logic [7:0]  wrdata;
   logic        wren;

   logic [7:0]  smem [256];
   logic [7:0]  expS [256];
   logic        initReq;
   logic [15:0] wlog [$];

   int assertCount;
   int failCount;
   int edges;

   ksa #(.KEYLEN(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .rdy    (rdy),
      .key    (key),
      .addr   (addr),
      .rddata (rddata),
      .wrdata (wrdata),
      .wren   (wren)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // S memory: synchronous read with one cycle of latency. initReq reloads
   // the identity permutation, standing in for the init stage.
   always @(posedge clk) begin
      if (initReq) begin
         for (int k = 0; k < 256; k++) smem[k] <= 8'(k);
      end else if (wren) begin
         smem[addr] <= wrdata;
      end
      rddata <= smem[addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic initS();
      @(negedge clk);
      initReq = 1'b1;
      @(negedge clk);
      initReq = 1'b0;
   endtask

   // Issue a start: en and key are presented on a negedge, the next posedge
   // is the start edge, and en is dropped afterwards unless hold is set.
   task automatic applyStimulus(input logic [23:0] k, input bit hold);
      @(negedge clk);
      key = k;
      en  = 1'b1;
      checkOutput("rdyBeforeStart", 32'(rdy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (!hold) en = 1'b0;
      checkOutput("rdyAfterStart", 32'(rdy), 32'd0);
   endtask

   // Counts cycles from the start edge until rdy is seen high again, with a
   // bounded budget. At cycle disturbAt en is pulsed and key is scrambled.
   task automatic waitDone(input int disturbAt, output int nEdges);
      int n;
      n = 1;
      while (!rdy && n < 4000) begin
         @(negedge clk);
         n++;
         if (n == disturbAt) begin
            en  = 1'b1;
            key = 24'hFFFFFF;
         end
         if (n == disturbAt + 1) en = 1'b0;
      end
      nEdges = n - 1;
   endtask

   task automatic modelIdentity();
      for (int k = 0; k < 256; k++) expS[k] = 8'(k);
   endtask

   task automatic modelKsa(input logic [23:0] k);
      logic [7:0] jj;
      logic [7:0] t;
      logic [7:0] kb;
      jj = 8'd0;
      for (int n = 0; n < 256; n++) begin
         case (n % 3)
            0:       kb = k[23:16];
            1:       kb = k[15:8];
            default: kb = k[7:0];
         endcase
         jj = jj + expS[n] + kb;
         t = expS[n];
         expS[n] = expS[jj];
         expS[jj] = t;
      end
   endtask

   task automatic compareS(input string tag);
      int diffs;
      diffs = 0;
      for (int k = 0; k < 256; k++) if (smem[k] !== expS[k]) diffs++;
      checkOutput(tag, 32'(diffs), 32'd0);
   endtask

   initial begin
      bit running;
      bit st;
      int cyc;
      int phase;
      int iter;
      bit seen [256];
      int missing;

      assertCount = 0;
      failCount   = 0;
      rst     = 1'b1;
      en      = 1'b1;
      key     = 24'd0;
      initReq = 1'b0;
      running = 1'b0;
      cyc     = 0;

      // Protocol monitor, sampled 1 time unit after each rising edge. Cycle
      // c of a run is phase (c-1)%6 of iteration (c-1)/6; phases 4 and 5 are
      // the two writes, phases 0 and 4 put i on addr.
      fork
         forever begin
            @(posedge clk);
            st = rdy && en && !rst;
            #1;
            if (rst) begin
               running = 1'b0;
            end else begin
               if (running) begin
                  if (cyc == 1536) begin
                     checkOutput("writesPerRun", 32'(wlog.size()), 32'd512);
                     running = 1'b0;
                  end else begin
                     cyc++;
                  end
               end
               if (!running && st) begin
                  running = 1'b1;
                  cyc = 1;
                  wlog.delete();
               end
               if (running) begin
                  phase = (cyc - 1) % 6;
                  iter  = (cyc - 1) / 6;
                  checkOutput("wrenPhase", 32'(wren), (phase >= 4) ? 32'd1 : 32'd0);
                  checkOutput("rdyBusy", 32'(rdy), 32'd0);
                  if (phase == 0 || phase == 4) checkOutput("addrI", 32'(addr), 32'(iter));
                  if (wren) wlog.push_back({addr, wrdata});
               end else begin
                  checkOutput("wrenIdle", 32'(wren), 32'd0);
               end
            end
         end
      join_none

      // Reset held for 10 cycles with en high: everything stays at zero.
      repeat (10) begin
         @(negedge clk);
         checkOutput("rstRdy", 32'(rdy), 32'd0);
         checkOutput("rstAddr", 32'(addr), 32'd0);
         checkOutput("rstWrdata", 32'(wrdata), 32'd0);
         checkOutput("rstWren", 32'(wren), 32'd0);
      end
      en  = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("rdyAtRelease", 32'(rdy), 32'd0);
      @(negedge clk);
      checkOutput("rdyOneEdgeLater", 32'(rdy), 32'd1);

      // Key 00033C with an en pulse and a key change mid-run.
      initS();
      applyStimulus(24'h00033C, 1'b0);
      waitDone(300, edges);
      checkOutput("run1Edges", 32'(edges), 32'd1536);
      checkOutput("run1Write2", 32'(wlog[2]), 32'h0104);
      checkOutput("run1Write3", 32'(wlog[3]), 32'h0401);
      checkOutput("run1Write4", 32'(wlog[4]), 32'h0242);
      checkOutput("run1Write5", 32'(wlog[5]), 32'h4202);
      modelIdentity();
      modelKsa(24'h00033C);
      compareS("run1FinalS");

      // All-zero key: i=1 swaps S[1] with itself.
      initS();
      applyStimulus(24'h000000, 1'b0);
      waitDone(0, edges);
      checkOutput("run2Edges", 32'(edges), 32'd1536);
      checkOutput("run2Write2", 32'(wlog[2]), 32'h0101);
      checkOutput("run2Write3", 32'(wlog[3]), 32'h0101);
      modelIdentity();
      modelKsa(24'h000000);
      compareS("run2FinalS");
      for (int k = 0; k < 256; k++) seen[k] = 1'b0;
      for (int k = 0; k < 256; k++) seen[smem[k]] = 1'b1;
      missing = 0;
      for (int k = 0; k < 256; k++) if (!seen[k]) missing++;
      checkOutput("run2Permutation", 32'(missing), 32'd0);

      // en held high across completion: a second run starts immediately.
      initS();
      applyStimulus(24'h00033C, 1'b1);
      waitDone(0, edges);
      checkOutput("run3Edges", 32'(edges), 32'd1536);
      @(negedge clk);
      checkOutput("run3Restart", 32'(rdy), 32'd0);
      en = 1'b0;
      waitDone(0, edges);
      checkOutput("run3SecondEdges", 32'(edges), 32'd1536);
      modelIdentity();
      modelKsa(24'h00033C);
      modelKsa(24'h00033C);
      compareS("run3FinalS");

      // Abort at cycle 700, then re-init and rerun from scratch.
      initS();
      applyStimulus(24'h00033C, 1'b0);
      repeat (699) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abortRdy", 32'(rdy), 32'd0);
      checkOutput("abortAddr", 32'(addr), 32'd0);
      checkOutput("abortWrdata", 32'(wrdata), 32'd0);
      checkOutput("abortWren", 32'(wren), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      initS();
      applyStimulus(24'h00033C, 1'b0);
      waitDone(0, edges);
      checkOutput("run4Edges", 32'(edges), 32'd1536);
      modelIdentity();
      modelKsa(24'h00033C);
      compareS("run4FinalS");

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/ksa.md
# ksa

Key-scheduling stage of the ARC4 core. Sits directly downstream of `init`: once `init` has filled the 256-byte S memory with S[i]=i, `ksa` permutes it in place using a 24-bit key, per the ARC4 key-scheduling algorithm. It shares the same single-port S memory and uses the same `en`/`rdy` handshake style as `init`. Its output feeds the PRGA stage.

## Interface
Parameters:
- `KEYLEN`, 3: key length in bytes; fixed at 3, with `key` width = 8*KEYLEN.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  start request; sampled only while `rdy`=1.
- `rdy`  out  1  high when idle and able to accept a request.
- `key`  in  24  ARC4 key, big-endian. key[0]=`key[23:16]`, key[1]=`key[15:8]`, key[2]=`key[7:0]`.
- `addr`  out  8  S memory address.
- `rddata`  in  8  S memory read data, valid one cycle after `addr`.
- `wrdata`  out  8  S memory write data.
- `wren`  out  1  S memory write enable; the write happens at the rising edge.

## Operation
Algorithm:
- j=0.
- For i=0..255: j=(j+S[i]+key[i mod 3]) mod 256, then swap S[i] and S[j].
- All arithmetic is 8-bit with natural wrap; no carries are kept.

Start:
- On a rising edge with `rdy`=1 and `en`=1, latch `key` into an internal register and clear i=0 and j=0.
- Go to READ_I; `rdy` drops.
- Changes to `key` after the start edge have no effect.

FSM states (one cycle each):
- IDLE: `rdy`=1, `addr`=0, `wrdata`=0, `wren`=0.
- READ_I: `addr`=i, `wren`=0.
- LATCH_I: capture si=`rddata`; j <= j+`rddata`+keybyte(i mod 3).
- READ_J: `addr`=j (the updated value), `wren`=0.
- LATCH_J: capture sj=`rddata`.
- WRITE_I: `addr`=i, `wrdata`=sj, `wren`=1.
- WRITE_J: `addr`=j, `wrdata`=si, `wren`=1. If i==255, go to IDLE; else i <= i+1 and go to READ_I.

Mod-3 index:
- Kept as a 2-bit counter 0,1,2,0…, reset to 0 at start.
- Must not be computed with a divider.

Boundary rules:
- i==j: both writes hit the same address with the same value (si=sj). This is the required, harmless behaviour; no special-casing.
- i wraps from 255: termination is decided by the i==255 test in WRITE_J. i never increments past 255.
- `en` while busy: ignored; no queueing.
- `en` held high continuously: a new run starts on the first edge with `rdy`=1.
- `wren` is never asserted outside WRITE_I and WRITE_J.

Reset:
- `rst`=1 asynchronously forces IDLE, with `rdy`=0, `addr`=0, `wrdata`=0, `wren`=0, i=j=0, and si, sj and the key register cleared.
- Reset mid-run aborts immediately. The S memory is left partially permuted; the controller must rerun `init` first.

## Timing
- Reset values: all outputs 0, including `rdy`.
- `rdy` rises on the first rising edge after `rst` deasserts.
- Iteration cost: 6 cycles.
- Full run: 256 iterations = 1536 cycles.
- Start edge E0: READ_I (i=0) occupies cycle 1.
- Last WRITE_J occupies cycle 1536; `rdy`=1 from cycle 1537, which is the 1536th rising edge after E0.
- Memory contract: synchronous read, 1-cycle latency. `addr` driven in cycle N gives data on `rddata` in cycle N+1. No read-during-write dependency is exercised, because writes never overlap reads.
- All outputs are registered, or decoded purely from registered state. There is no combinational path from `rddata` to `addr`, `wrdata` or `wren` in the same cycle.

## Test plan
- Reset: hold `rst`=1 for 10 cycles with `en`=1 → `rdy`=0, `addr`=0, `wrdata`=0, `wren`=0 throughout; no write. Release → `rdy`=1 one edge later.
- Key 24'h00033C on identity S:
  - i=0: no change.
  - i=1: j=4; writes (addr 1, data 4) then (addr 4, data 1).
  - i=2: j=66; writes (addr 2, data 66) then (addr 66, data 2).
  - `rdy` returns high exactly 1536 edges after the start edge.
  - Final S matches a software ARC4 KSA model byte-for-byte.
- Key 24'h000000: i=1 gives j=1 → two writes to addr 1, both data 1. Final S matches the model, and S remains a permutation of 0..255.
- Handshake:
  - Pulse `en` mid-run and change `key` mid-run → no restart, result unchanged.
  - Hold `en`=1 across completion → a second run starts on the edge where `rdy`=1 and `rdy` drops the next cycle.
- Abort: assert `rst` at cycle 700 → outputs 0 immediately, `wren`=0. Re-init S, restart with key 24'h00033C → final S equals the uninterrupted result.
- Protocol monitor for all runs:
  - `wren`=1 only in write cycles.
  - Exactly 512 writes per run.
  - `addr` in READ_I and WRITE_I equals an i that increments 0..255 exactly once each.
